// File: rtl/branch_predictor.sv
// Gshare direction predictor with a direct-mapped tagged BTB and a speculative global history.
// Lookup is combinational; training and GHR updates take effect on the rising clock edge.
module branch_predictor #(
   parameter int unsigned GH       = 4,
   parameter int unsigned PHT_BITS = 4,
   parameter int unsigned BTB_BITS = 4,
   parameter int unsigned IDX_LSB  = 4
) (
   input  logic          clock_i,
   input  logic          reset_i,
   input  logic          predict_req_valid_i,
   input  logic [31:0]   predict_req_pc_i,
   input  logic          predict_req_used_i,
   output logic          predict_taken_o,
   output logic [31:0]   predict_target_o,
   output logic [GH-1:0] predict_ghr_snapshot_o,
   input  logic          train_valid_i,
   input  logic [31:0]   train_pc_i,
   input  logic          train_actual_taken_i,
   input  logic [31:0]   train_actual_target_i,
   input  logic [GH-1:0] train_ghr_snapshot_i,
   input  logic          recover_mispredict_pulse_i,
   input  logic [GH-1:0] recover_ghr_snapshot_i
);

   localparam int PhtN = 1 << PHT_BITS;
   localparam int BtbN = 1 << BTB_BITS;
   localparam int TagW = 32 - IDX_LSB - BTB_BITS;

   logic [GH-1:0]   ghr_q, ghr_d;
   logic [1:0]      pht_q [PhtN];
   logic [1:0]      pht_d [PhtN];
   logic            btb_valid_q [BtbN];
   logic            btb_valid_d [BtbN];
   logic [TagW-1:0] btb_tag_q [BtbN];
   logic [TagW-1:0] btb_tag_d [BtbN];
   logic [31:0]     btb_tgt_q [BtbN];
   logic [31:0]     btb_tgt_d [BtbN];

   logic [PHT_BITS-1:0] pred_pht_idx, train_pht_idx;
   logic [BTB_BITS-1:0] pred_btb_idx, train_btb_idx;
   logic [TagW-1:0]     pred_tag, train_tag;
   logic                pred_hit;
   logic                unused_pc_bits;

   assign pred_pht_idx  = predict_req_pc_i[IDX_LSB +: PHT_BITS] ^ PHT_BITS'(ghr_q);
   assign train_pht_idx = train_pc_i[IDX_LSB +: PHT_BITS] ^ PHT_BITS'(train_ghr_snapshot_i);
   assign pred_btb_idx  = predict_req_pc_i[IDX_LSB +: BTB_BITS];
   assign train_btb_idx = train_pc_i[IDX_LSB +: BTB_BITS];
   assign pred_tag      = predict_req_pc_i[31 -: TagW];
   assign train_tag     = train_pc_i[31 -: TagW];
   // Offset bits below the indexing granularity never affect a prediction.
   assign unused_pc_bits = ^{predict_req_pc_i[IDX_LSB-1:0], train_pc_i[IDX_LSB-1:0]};

   assign pred_hit = btb_valid_q[pred_btb_idx] && (btb_tag_q[pred_btb_idx] == pred_tag);
   assign predict_taken_o        = predict_req_valid_i & pht_q[pred_pht_idx][1] & pred_hit;
   assign predict_target_o       = predict_taken_o ? btb_tgt_q[pred_btb_idx] : 32'h0;
   assign predict_ghr_snapshot_o = ghr_q;

   // Recovery wins over a same-cycle speculative shift.
   always_comb begin
      ghr_d = ghr_q;
      if (recover_mispredict_pulse_i) begin
         ghr_d = recover_ghr_snapshot_i;
      end else if (predict_req_valid_i && predict_req_used_i) begin
         ghr_d = {ghr_q[GH-2:0], predict_taken_o};
      end
   end

   always_comb begin
      pht_d       = pht_q;
      btb_valid_d = btb_valid_q;
      btb_tag_d   = btb_tag_q;
      btb_tgt_d   = btb_tgt_q;
      if (train_valid_i) begin
         if (train_actual_taken_i) begin
            if (pht_q[train_pht_idx] != 2'd3) begin
               pht_d[train_pht_idx] = pht_q[train_pht_idx] + 2'd1;
            end
            btb_valid_d[train_btb_idx] = 1'b1;
            btb_tag_d[train_btb_idx]   = train_tag;
            btb_tgt_d[train_btb_idx]   = train_actual_target_i;
         end else if (pht_q[train_pht_idx] != 2'd0) begin
            pht_d[train_pht_idx] = pht_q[train_pht_idx] - 2'd1;
         end
      end
   end

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         ghr_q <= '0;
         for (int i = 0; i < PhtN; i++) begin
            pht_q[i] <= 2'd1;
         end
         for (int i = 0; i < BtbN; i++) begin
            btb_valid_q[i] <= 1'b0;
            btb_tag_q[i]   <= '0;
            btb_tgt_q[i]   <= '0;
         end
      end else begin
         ghr_q       <= ghr_d;
         pht_q       <= pht_d;
         btb_valid_q <= btb_valid_d;
         btb_tag_q   <= btb_tag_d;
         btb_tgt_q   <= btb_tgt_d;
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized scoreboard bench for branch_predictor against an array-based reference model.
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        p_valid = 1'b0;
   logic [31:0] p_pc = '0;
   logic        p_used = 1'b0;
   logic        p_taken;
   logic [31:0] p_target;
   logic [3:0]  p_snap;
   logic        t_valid = 1'b0;
   logic [31:0] t_pc = '0;
   logic        t_taken = 1'b0;
   logic [31:0] t_target = '0;
   logic [3:0]  t_snap = '0;
   logic        r_pulse = 1'b0;
   logic [3:0]  r_snap = '0;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic        taken;
      logic [31:0] target;
      logic [3:0]  snap;
   } exp_t;
   exp_t exp_q[$];

   // Reference model state
   int unsigned pht_m [16];
   bit          bv_m [16];
   int unsigned btag_m [16];
   logic [31:0] btgt_m [16];
   int unsigned ghr_m;

   branch_predictor dut (
      .clock_i                    (clk),
      .reset_i                    (rst_n),
      .predict_req_valid_i        (p_valid),
      .predict_req_pc_i           (p_pc),
      .predict_req_used_i         (p_used),
      .predict_taken_o            (p_taken),
      .predict_target_o           (p_target),
      .predict_ghr_snapshot_o     (p_snap),
      .train_valid_i              (t_valid),
      .train_pc_i                 (t_pc),
      .train_actual_taken_i       (t_taken),
      .train_actual_target_i      (t_target),
      .train_ghr_snapshot_i       (t_snap),
      .recover_mispredict_pulse_i (r_pulse),
      .recover_ghr_snapshot_i     (r_snap)
   );

   always #5 clk = ~clk;

   function automatic void model_reset();
      ghr_m = 0;
      for (int i = 0; i < 16; i++) begin
         pht_m[i] = 1;
         bv_m[i]  = 0;
      end
   endfunction

   function automatic exp_t model_predict(bit valid, logic [31:0] pc);
      exp_t e;
      int unsigned bi = (pc / 16) % 16;
      int unsigned pi = ((pc / 16) % 16) ^ ghr_m;
      bit hit = bv_m[bi] && (btag_m[bi] == pc / 256);
      e.taken  = valid && (pht_m[pi] >= 2) && hit;
      e.target = e.taken ? btgt_m[bi] : 32'h0;
      e.snap   = 4'(ghr_m);
      return e;
   endfunction

   function automatic void model_edge(bit pt);
      if (r_pulse) ghr_m = r_snap;
      else if (p_valid && p_used) ghr_m = (ghr_m * 2 + pt) % 16;
      if (t_valid) begin
         int unsigned pi = ((t_pc / 16) % 16) ^ t_snap;
         int unsigned bi = (t_pc / 16) % 16;
         if (t_taken) begin
            if (pht_m[pi] < 3) pht_m[pi]++;
            bv_m[bi]   = 1;
            btag_m[bi] = t_pc / 256;
            btgt_m[bi] = t_target;
         end else if (pht_m[pi] > 0) begin
            pht_m[pi]--;
         end
      end
   endfunction

   task automatic cyc(bit v, logic [31:0] pc, bit used, bit tv, logic [31:0] tpc, bit tt,
                      logic [31:0] ttgt, logic [3:0] tsn, bit rec, logic [3:0] rsn);
      exp_t e;
      p_valid = v; p_pc = pc; p_used = used;
      t_valid = tv; t_pc = tpc; t_taken = tt; t_target = ttgt; t_snap = tsn;
      r_pulse = rec; r_snap = rsn;
      e = model_predict(v, pc);
      if (v) exp_q.push_back(e);
      @(posedge clk);
      if (rst_n) model_edge(e.taken);
      #1;
   endtask

   task automatic train(logic [31:0] pc, bit tk, logic [31:0] tgt, logic [3:0] sn);
      cyc(0, 0, 0, 1, pc, tk, tgt, sn, 0, 0);
   endtask

   task automatic look(logic [31:0] pc, bit used);
      cyc(1, pc, used, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Reset asserted mid-cycle with a lookup, train and recover all pending.
   task automatic do_reset(logic [31:0] pc);
      exp_t e;
      rst_n = 1'b0;
      model_reset();
      p_valid = 1; p_pc = pc; p_used = 1;
      t_valid = 1; t_pc = pc; t_taken = 1; t_target = 32'h1234; t_snap = 0;
      r_pulse = 1; r_snap = 4'hF;
      e = model_predict(1, pc);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      p_valid = 0; t_valid = 0; r_pulse = 0;
   endtask

   task automatic check(string name, logic [31:0] act, logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%h required=%h", name, act, req);
      end
   endtask

   // Monitor: sample away from the active edge and compare against the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (p_valid) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL scoreboard_empty: actual=output required=expectation");
            end else begin
               e = exp_q.pop_front();
               check("taken", {31'b0, p_taken}, {31'b0, e.taken});
               check("target", p_target, e.target);
               check("snapshot", {28'b0, p_snap}, {28'b0, e.snap});
            end
         end
      end
   end

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      do_reset(32'h40);
      repeat (3) train(32'h40, 0, 0, 0);
      look(32'h40, 0);

      do_reset(32'h80);
      repeat (3) train(32'h80, 1, 32'h800, 0);
      look(32'h80, 0);

      repeat (4) train(32'hC0, 1, 32'hC00, 0);
      look(32'hC0, 0);
      repeat (5) train(32'hC0, 0, 0, 0);
      look(32'hC0, 0);
      repeat (2) train(32'hC0, 1, 32'hC00, 0);
      look(32'hC0, 0);

      repeat (3) train(32'h100, 1, 32'h888, 0);
      repeat (3) train(32'h140, 0, 0, 0);
      look(32'h140, 0);
      look(32'h100, 0);
      train(32'h80, 1, 32'h800, 0);
      look(32'h180, 0);

      look(32'h80, 1);
      look(32'h80, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 4'h0);
      look(32'h80, 0);
      look(32'h80, 0);

      cyc(1, 32'h80, 1, 0, 0, 0, 0, 0, 1, 4'hA);
      look(32'h80, 0);
      do_reset(32'h80);
      look(32'h80, 0);

      for (int i = 0; i < 400; i++) begin
         logic [31:0] pc, tpc;
         pc  = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 4)
               | 32'($urandom_range(0, 15));
         tpc = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 4);
         cyc(1'($urandom_range(0, 3) != 0), pc, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), tpc, 1'($urandom_range(0, 2) != 0), $urandom,
             4'($urandom_range(0, 15)), 1'($urandom_range(0, 9) == 0), 4'($urandom_range(0, 15)));
      end
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_drain: actual=%0d left required=0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
